// File: rtl/regfile.sv
// regfile: MIPS32 general-purpose register file with a pending-write scoreboard.
// Two combinational read ports (rs/rt) serve decode, and one clocked write port
// serves write-back. Each of r1..r31 has a small saturating counter. Decode
// reserves a destination at issue and write-back releases it. Decode uses
// pend1/pend2 to spot operands whose producing write has not retired yet.
// r0 has no storage and no counter. It always reads zero and is never pending.
// Optional build macro: REGFILE_BYPASS_EN. When defined, a same-cycle write is
// forwarded to a matching read port. A read of a register whose last
// reservation is retiring in that cycle then reports not-pending.
module regfile #(
    parameter int PEND_W   = 2,
    parameter int MAX_PEND = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        rsv_en,
    input  logic [4:0]  rsv_addr,
    output logic        pend1,
    output logic        pend2,
    output logic        rsv_ovf
);

    localparam logic [PEND_W-1:0] LP_MAX  = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] LP_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] LP_ZERO = '0;

    logic [31:0]       r_regs [1:31];
    logic [PEND_W-1:0] r_cnt  [1:31];
    logic              r_rsv_ovf;

    logic              w_inc  [1:31];
    logic              w_dec  [1:31];
    logic              w_ovf_set;
    logic [31:0]       w_rdata1;
    logic [31:0]       w_rdata2;
    logic              w_pend1;
    logic              w_pend2;

    // Decode reserve/release requests per register and detect a reservation hitting a saturated counter
    always_comb begin
        w_ovf_set = 1'b0;
        for (int i = 1; i < 32; i++) begin
            w_inc[i] = rsv_en && (rsv_addr == 5'(i));
            w_dec[i] = we && (waddr == 5'(i)) && (r_cnt[i] != LP_ZERO);
            if (w_inc[i] && !w_dec[i] && (r_cnt[i] >= LP_MAX)) begin
                w_ovf_set = 1'b1;
            end
        end
    end

    // Register storage, pending counters and the sticky overflow flag; reset discards writes and reservations
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_rsv_ovf <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we && (waddr == 5'(i))) begin
                    r_regs[i] <= wdata;
                end
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_cnt[i] < LP_MAX) begin
                        r_cnt[i] <= r_cnt[i] + LP_ONE;
                    end
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - LP_ONE;
                end
            end
            if (w_ovf_set) begin
                r_rsv_ovf <= 1'b1;
            end
        end
    end

    // Port 1 (rs) read data and pending flag, forced quiet during reset and for r0
    always_comb begin
        w_rdata1 = '0;
        w_pend1  = 1'b0;
        if (!rst && re1 && (raddr1 != 5'd0)) begin
            w_rdata1 = r_regs[raddr1];
            w_pend1  = (r_cnt[raddr1] != LP_ZERO);
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr1)) begin
                w_rdata1 = wdata;
                if (r_cnt[raddr1] == LP_ONE) begin
                    w_pend1 = 1'b0;
                end
            end
`endif
        end
    end

    // Port 2 (rt) read data and pending flag, same rules as port 1
    always_comb begin
        w_rdata2 = '0;
        w_pend2  = 1'b0;
        if (!rst && re2 && (raddr2 != 5'd0)) begin
            w_rdata2 = r_regs[raddr2];
            w_pend2  = (r_cnt[raddr2] != LP_ZERO);
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr2)) begin
                w_rdata2 = wdata;
                if (r_cnt[raddr2] == LP_ONE) begin
                    w_pend2 = 1'b0;
                end
            end
`endif
        end
    end

    assign rdata1  = w_rdata1;
    assign rdata2  = w_rdata2;
    assign pend1   = w_pend1;
    assign pend2   = w_pend2;
    assign rsv_ovf = r_rsv_ovf;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard-driven bench for regfile. Each scenario task drives one
// cycle at a time. It queues the values expected on the outputs for that cycle,
// then pops and compares them on the falling edge. Expectations follow the
// REGFILE_BYPASS_EN build setting.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        pend1;
    logic        pend2;
    logic        rsv_ovf;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        total = 0;
    int        bad   = 0;

    regfile #(.PEND_W(2), .MAX_PEND(3)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend1(pend1), .pend2(pend2), .rsv_ovf(rsv_ovf)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return rdata1;
            1:       return rdata2;
            2:       return {31'b0, pend1};
            3:       return {31'b0, pend2};
            4:       return {31'b0, rsv_ovf};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(string name, int sel, logic [31:0] val);
        sb.push_back('{name, sel, val});
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D;
                    re1 = 1'b1; raddr1 = 5'd5; rsv_en = 1'b1; rsv_addr = 5'd5;
                    expect_val("rst_rdata1", 0, 32'h0);
                    expect_val("rst_pend1", 2, 32'h0);
                end
                default: begin
                    re1 = 1'b1; raddr1 = 5'd5;
                    expect_val("post_rst_rdata1", 0, 32'h0);
                    expect_val("post_rst_pend1", 2, 32'h0);
                    expect_val("post_rst_ovf", 4, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
                    re1 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;
                    expect_val("wr_cycle_rdata1", 0, BYP ? 32'h1234_5678 : 32'h0);
                    expect_val("wr_cycle_rdata2_disabled", 1, 32'h0);
                end
                default: begin
                    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
                    expect_val("wr_next_rdata1", 0, 32'h1234_5678);
                    expect_val("wr_next_rdata2", 1, 32'h1234_5678);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r0();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
                    rsv_en = 1'b1; rsv_addr = 5'd0;
                    re1 = 1'b1; raddr1 = 5'd0;
                    expect_val("r0_wr_rdata1", 0, 32'h0);
                end
                default: begin
                    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
                    expect_val("r0_rdata1", 0, 32'h0);
                    expect_val("r0_rdata2", 1, 32'h0);
                    expect_val("r0_pend1", 2, 32'h0);
                    expect_val("r0_pend2", 3, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reserve();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 5; c++) begin
            idle();
            re2 = 1'b1; raddr2 = 5'd3;
            re1 = 1'b1; raddr1 = 5'd5;
            case (c)
                0: begin
                    rsv_en = 1'b1; rsv_addr = 5'd3;
                    expect_val("rsv0_pend2", 3, 32'h0);
                end
                1: begin
                    rsv_en = 1'b1; rsv_addr = 5'd3;
                    expect_val("rsv1_pend2", 3, 32'h1);
                    expect_val("rsv1_indep_rdata1", 0, 32'h1234_5678);
                    expect_val("rsv1_pend1_other", 2, 32'h0);
                end
                2: begin
                    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0011;
                    expect_val("wr1_pend2", 3, 32'h1);
                    expect_val("wr1_rdata2", 1, BYP ? 32'h0000_0011 : 32'h0);
                end
                3: begin
                    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0022;
                    expect_val("wr2_pend2", 3, BYP ? 32'h0 : 32'h1);
                    expect_val("wr2_rdata2", 1, BYP ? 32'h0000_0022 : 32'h0000_0011);
                end
                default: begin
                    expect_val("released_pend2", 3, 32'h0);
                    expect_val("released_rdata2", 1, 32'h0000_0022);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 3; c++) begin
            idle();
            re1 = 1'b1; raddr1 = 5'd7;
            case (c)
                0: begin
                    rsv_en = 1'b1; rsv_addr = 5'd7;
                    expect_val("r7_pre_pend1", 2, 32'h0);
                end
                1: begin
                    rsv_en = 1'b1; rsv_addr = 5'd7;
                    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
                    expect_val("r7_same_pend1", 2, BYP ? 32'h0 : 32'h1);
                    expect_val("r7_same_rdata1", 0, BYP ? 32'hA5A5_A5A5 : 32'h0);
                end
                default: begin
                    expect_val("r7_after_pend1", 2, 32'h1);
                    expect_val("r7_after_rdata1", 0, 32'hA5A5_A5A5);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        sb_entry_t e;
        logic [31:0] act;
        for (int c = 0; c < 11; c++) begin
            idle();
            re2 = 1'b1; raddr2 = 5'd9;
            if (c < 4) begin
                rsv_en = 1'b1; rsv_addr = 5'd9;
                expect_val("ovf_fill_pend2", 3, (c == 0) ? 32'h0 : 32'h1);
                expect_val("ovf_fill_flag", 4, 32'h0);
            end else if (c < 7) begin
                we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0090 + 32'(c);
                expect_val("ovf_flag_sticky", 4, 32'h1);
                expect_val("ovf_drain_pend2", 3, (c == 6 && BYP) ? 32'h0 : 32'h1);
            end else if (c == 7) begin
                rsv_en = 1'b1; rsv_addr = 5'd9;
                expect_val("ovf_drained_pend2", 3, 32'h0);
                expect_val("ovf_drained_rdata2", 1, 32'h0000_0096);
            end else if (c == 8) begin
                rst = 1'b1;
                expect_val("ovf_in_rst_pend2", 3, 32'h0);
                expect_val("ovf_in_rst_rdata2", 1, 32'h0);
            end else begin
                expect_val("ovf_post_rst_flag", 4, 32'h0);
                expect_val("ovf_post_rst_pend2", 3, 32'h0);
                expect_val("ovf_post_rst_rdata2", 1, 32'h0);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Scenario sequence: initial reset, then each feature in turn, then summary
    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_r0();
        test_reserve();
        test_back_to_back();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the MIPS32 core. It is the responder to the decode stage's two read ports (rs/rt) and accepts one write per cycle from the write-back stage.
- Adds a per-register pending-write scoreboard. Decode reserves its destination at issue; write-back releases it. Decode uses `pend1`/`pend2` to detect operands not yet written.
- Sits between id and wb; read paths are combinational, storage is clocked.

Parameters:
- PEND_W, 2, width of each per-register pending counter.
- MAX_PEND, 3, saturation value of a pending counter. Must be ≤ 2^PEND_W−1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write enable from write-back
- waddr  input  5  write register index
- wdata  input  32  write data
- re1  input  1  read enable, port 1 (rs)
- raddr1  input  5  read index, port 1
- rdata1  output  32  read data, port 1 (combinational)
- re2  input  1  read enable, port 2 (rt)
- raddr2  input  5  read index, port 2
- rdata2  output  32  read data, port 2 (combinational)
- rsv_en  input  1  reserve destination at issue (decode write-enable)
- rsv_addr  input  5  destination index to reserve
- pend1  output  1  port-1 register has an outstanding reserved write
- pend2  output  1  port-2 register has an outstanding reserved write
- rsv_ovf  output  1  sticky: reservation attempted on a saturated counter

Behaviour:
- Storage: 31 × 32-bit registers (r1–r31). r0 has no storage: it always reads 0, writes to it are ignored, and it is never reserved.
- Reset (rst=1 at clk edge): all registers := 0, all pending counters := 0, rsv_ovf := 0.
- While rst=1: rdata1/rdata2 = 0 and pend1/pend2 = 0, regardless of other inputs.
- Write timing: on a clk edge with we=1 and waddr≠0, reg[waddr] := wdata. The new value is visible on the read ports from the next cycle.
- Read data, port n:
  - 0 if ren=0 or raddrn=0;
  - otherwise the bypass value (Optional Feature), if the bypass applies;
  - otherwise reg[raddrn].
  - Both ports are independent and may address the same register.
- Pending counter cnt[i], updated on each clk edge (i≠0):
  - inc = rsv_en && rsv_addr==i;
  - dec = we && waddr==i && cnt[i]≠0.
  - inc and dec together: cnt holds.
  - inc only: cnt+1 if cnt<MAX_PEND; otherwise cnt holds and rsv_ovf := 1.
  - dec only: cnt−1.
  - A write to a register whose cnt=0 is a plain write; cnt stays 0 (no underflow).
- Pending flag, port n: pendn = ren && raddrn≠0 && cnt[raddrn]≠0. The bypass exception is defined under Optional Feature.
- rsv_ovf clears only on rst.
- Reset mid-operation: all outstanding reservations are discarded; writes in the same cycle as rst are dropped.

Optional Feature:
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - If we=1, waddr≠0, waddr==raddrn and ren=1, then rdata_n = wdata in the same cycle (write-before-read).
  - pend_n is forced to 0 in that cycle when cnt[raddrn]==1, because this write retires the last reservation.
- Undefined:
  - No bypass; rdata_n returns the stored (old) value in the write cycle.
  - pend_n uses the unmodified counter.

Test Plan:
- Reset, then re1=1, raddr1=5 → rdata1=0x00000000, pend1=0, rsv_ovf=0.
- Cycle N: we=1, waddr=5, wdata=0x12345678, re1=1, raddr1=5.
  - Cycle N: rdata1=0x12345678 with bypass, 0 without.
  - Cycle N+1: rdata1=0x12345678 in both builds.
- we=1, waddr=0, wdata=0xFFFFFFFF; next cycle raddr1=raddr2=0, re1=re2=1 → rdata1=rdata2=0; rsv_en to r0 → pend stays 0.
- rsv_en, rsv_addr=3 on two consecutive cycles; raddr2=3, re2=1 → pend2=1.
  - After first we to r3 → pend2=1.
  - After second we to r3 → pend2=0.
  - With bypass, pend2=0 already during the second write cycle.
- With cnt[7]=1: rsv_en (rsv_addr=7) and we (waddr=7, wdata=0xA5A5A5A5) in the same cycle → cnt[7] stays 1, pend1=1 on r7 next cycle, rdata1=0xA5A5A5A5.
- rsv_en to r9 on four consecutive cycles (MAX_PEND=3) → rsv_ovf=1 after the fourth edge, cnt[9]=3. Then assert rst for one cycle → rsv_ovf=0, pend on r9=0, reg[9]=0.
